// File: rtl/mmio_bus_fabric.sv
// ============================================================================
// mmio_bus_fabric : table-driven MMIO decoder with per-slave read latency
// Rev 1.0
// ============================================================================
`default_nettype none

module mmio_bus_fabric #(
  parameter int                  N_SLV    = 4,
  parameter logic [N_SLV*32-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                             32'h1000_0000, 32'h0000_0000},
  parameter logic [N_SLV*32-1:0] SLV_MASK = {4{32'hF000_0000}},
  parameter logic [N_SLV*3-1:0]  SLV_RLAT = {3'd0, 3'd0, 3'd1, 3'd1}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m_req,
  input  logic                  m_we,
  input  logic [31:0]           m_addr,
  input  logic [31:0]           m_wdata,
  input  logic [3:0]            m_be,
  output logic                  m_ready,
  output logic                  m_err,
  output logic [31:0]           m_rdata,
  output logic [N_SLV-1:0]      s_sel,
  output logic                  s_we,
  output logic [31:0]           s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_be,
  input  logic [N_SLV*32-1:0]   s_rdata,
  output logic [15:0]           err_cnt
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_WAIT   = 2'd2;
  localparam logic [1:0] c_RESP   = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_err;
  logic [2:0]       r_cnt;
  logic             w_hit;
  logic [IDX_W-1:0] w_hit_idx;
  logic [2:0]       w_rlat;
  logic [31:0]      w_slv_rdata;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  assign w_rlat      = SLV_RLAT[r_idx*3 +: 3];
  assign w_slv_rdata = s_rdata[r_idx*32 +: 32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (m_req) w_state_nxt = w_hit ? c_ACCESS : c_RESP;
      c_ACCESS: w_state_nxt = (s_we || (w_rlat == 3'd0)) ? c_RESP : c_WAIT;
      c_WAIT:   if (r_cnt == 3'd1) w_state_nxt = c_RESP;
      c_RESP:   w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  // Outputs decode from state alone so an async reset drops them instantly.
  always_comb begin
    s_sel   = (r_state == c_ACCESS) ? (N_SLV'(1) << r_idx) : '0;
    m_ready = (r_state == c_RESP);
    m_err   = (r_state == c_RESP) && r_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_be    <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      m_rdata <= '0;
      err_cnt <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (m_req) begin
            s_we    <= m_we;
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            s_be    <= m_be;
            r_idx   <= w_hit_idx;
            r_err   <= ~w_hit;
          end
        end
        c_ACCESS: begin
          r_cnt <= w_rlat;
          if (!s_we && (w_rlat == 3'd0)) m_rdata <= w_slv_rdata;
        end
        c_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) m_rdata <= w_slv_rdata;
        end
        c_RESP: begin
          if (r_err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mmio_bus_fabric.sv
// ============================================================================
// tb_mmio_bus_fabric : randomized scoreboard bench for mmio_bus_fabric
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mmio_bus_fabric;

  localparam int N = 5;
  // Slaves 1 and 2 overlap on 0x10xx_xxxx; slave 4 is the long-latency one.
  localparam logic [N*32-1:0] TB_BASE = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000,
                                         32'h1000_0000, 32'h0000_0000};
  localparam logic [N*32-1:0] TB_MASK = {32'hF000_0000, 32'hF000_0000, 32'hFF00_0000,
                                         32'hF000_0000, 32'hF000_0000};
  localparam logic [N*3-1:0]  TB_RLAT = {3'd4, 3'd0, 3'd2, 3'd1, 3'd1};

  logic          clk = 1'b0;
  logic          reset;
  logic          m_req, m_we;
  logic [31:0]   m_addr, m_wdata;
  logic [3:0]    m_be;
  logic          m_ready, m_err;
  logic [31:0]   m_rdata;
  logic [N-1:0]  s_sel;
  logic          s_we;
  logic [31:0]   s_addr, s_wdata;
  logic [3:0]    s_be;
  logic [N*32-1:0] s_rdata;
  logic [15:0]   err_cnt;

  mmio_bus_fabric #(
    .N_SLV(N), .SLV_BASE(TB_BASE), .SLV_MASK(TB_MASK), .SLV_RLAT(TB_RLAT)
  ) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_ready(m_ready), .m_err(m_err),
    .m_rdata(m_rdata), .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_be(s_be), .s_rdata(s_rdata), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          err;
    logic [31:0] rdata;
    int          sel_cyc;
    int          rdy_cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          sel_seen;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [31:0] model_rdata = 32'd0;
  logic [31:0] rd_val[N];
  int          age[N];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & TB_MASK[i*32 +: 32]) == TB_BASE[i*32 +: 32]) return i;
    return -1;
  endfunction

  function automatic int ref_rlat(input int i);
    return int'(TB_RLAT[i*3 +: 3]);
  endfunction

  // Slave model: correct data only in the one cycle it is sampled, junk otherwise.
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < N; i++) begin
      if (reset)                          age[i] <= 0;
      else if (s_sel[i])                  age[i] <= 1;
      else if (age[i] > 0 && age[i] < 15) age[i] <= age[i] + 1;
    end
  end

  always_comb begin
    s_rdata = '0;
    for (int i = 0; i < N; i++) begin
      if ((s_sel[i] && ref_rlat(i) == 0) || (ref_rlat(i) != 0 && age[i] == ref_rlat(i)))
        s_rdata[i*32 +: 32] = rd_val[i];
      else
        s_rdata[i*32 +: 32] = ~rd_val[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Monitor: compares everything the DUT presents against the scoreboard front.
  always @(negedge clk) begin
    chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
    if (s_sel != '0) begin
      if (sbq.size() == 0) chk("s_sel with no request", 32'(s_sel), 32'd0);
      else begin
        chk("s_sel", 32'(s_sel), (sbq[0].idx >= 0) ? (32'd1 << sbq[0].idx) : 32'd0);
        chk("s_sel cycle", 32'(cyc), 32'(sbq[0].sel_cyc));
        chk("s_sel repeat", 32'(sbq[0].sel_seen), 32'd0);
        chk("s_addr", s_addr, sbq[0].addr);
        chk("s_wdata", s_wdata, sbq[0].wdata);
        chk("s_we", 32'(s_we), 32'(sbq[0].we));
        chk("s_be", 32'(s_be), 32'(sbq[0].be));
        sbq[0].sel_seen = 1'b1;
      end
    end
    if (m_ready) begin
      if (sbq.size() == 0) chk("unexpected m_ready", 32'(m_ready), 32'd0);
      else begin
        mon_e = sbq.pop_front();
        chk("m_err", 32'(m_err), 32'(mon_e.err));
        chk("m_rdata", m_rdata, mon_e.rdata);
        chk("m_ready cycle", 32'(cyc), 32'(mon_e.rdy_cyc));
        chk("s_sel seen", 32'(mon_e.sel_seen), (mon_e.idx >= 0) ? 32'd1 : 32'd0);
        if (mon_e.err) exp_cnt = (exp_cnt == 16'hFFFF) ? 16'hFFFF : exp_cnt + 16'd1;
      end
    end
  end

  function automatic exp_t make_exp(input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    e.idx = ref_decode(addr);
    e.err = (e.idx < 0);
    e.we = we; e.addr = addr; e.wdata = wdata; e.be = be;
    e.sel_seen = 1'b0;
    e.sel_cyc = cyc + 1;
    if (e.idx < 0)  e.rdy_cyc = cyc + 1;
    else if (we)    e.rdy_cyc = cyc + 2;
    else            e.rdy_cyc = cyc + 2 + ref_rlat(e.idx);
    e.rdata = 32'd0;
    return e;
  endfunction

  // Called at a negedge with the fabric idle; returns at the m_ready negedge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] sval);
    exp_t e;
    bit   got;
    e = make_exp(we, addr, wdata, be);
    if (e.idx >= 0) begin
      rd_val[e.idx] = sval;
      if (!we) model_rdata = sval;
    end
    e.rdata = model_rdata;
    sbq.push_back(e);
    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; m_be = be;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL response timeout: no m_ready for addr %h within 20 cycles", addr);
      sbq.delete();
    end
    m_req = 1'b0;
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
    for (int i = 0; i < N; i++) rd_val[i] = $urandom;
    repeat (3) @(negedge clk);
    chk("reset m_ready", 32'(m_ready), 32'd0);
    chk("reset m_err", 32'(m_err), 32'd0);
    chk("reset m_rdata", m_rdata, 32'd0);
    chk("reset s_sel", 32'(s_sel), 32'd0);
    chk("reset s_we", 32'(s_we), 32'd0);
    chk("reset s_addr", s_addr, 32'd0);
    chk("reset s_wdata", s_wdata, 32'd0);
    chk("reset s_be", 32'(s_be), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, $urandom); @(negedge clk);
    issue(1'b0, 32'h2000_0004, 32'h0, 4'hF, 32'hA5A5_0001);    @(negedge clk);
    issue(1'b0, 32'h0000_0008, 32'h0, 4'hF, 32'h5A5A_0002);    @(negedge clk);
    issue(1'b0, 32'h5000_0000, 32'h0, 4'hF, $urandom);         @(negedge clk);
    issue(1'b0, 32'h1000_0000, 32'h0, 4'h3, $urandom);         @(negedge clk);
    issue(1'b1, 32'h5000_0004, $urandom, 4'h1, $urandom);      @(negedge clk);

    for (int n = 0; n < 400; n++) begin
      issue(1'($urandom_range(0, 1)),
            {4'($urandom_range(0, 7)), 28'($urandom)},
            $urandom, 4'($urandom), $urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Abort a latency-4 read in WAIT: outputs must clear without a clock edge.
    e = make_exp(1'b0, 32'h4000_0100, 32'h0, 4'hF);
    rd_val[4] = $urandom;
    sbq.push_back(e);
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h4000_0100; m_wdata = '0; m_be = 4'hF;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async reset s_sel", 32'(s_sel), 32'd0);
    chk("async reset m_ready", 32'(m_ready), 32'd0);
    chk("async reset m_rdata", m_rdata, 32'd0);
    chk("async reset s_addr", s_addr, 32'd0);
    chk("async reset err_cnt", 32'(err_cnt), 32'd0);
    sbq.delete();
    model_rdata = 32'd0;
    exp_cnt = 16'd0;
    m_req = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'h4000_0200, 32'h0, 4'hF, $urandom); @(negedge clk);
    issue(1'b0, 32'h7000_0000, 32'h0, 4'hF, $urandom); @(negedge clk);

    // Preload the counter near its ceiling, then drive it past saturation.
    @(posedge clk);
    #2;
    force dut.err_cnt = 16'hFFFD;
    exp_cnt = 16'hFFFD;
    #1 release dut.err_cnt;
    @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      issue(1'b0, 32'h6000_0000 | 32'(n), 32'h0, 4'hF, $urandom);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("err_cnt saturated", 32'(err_cnt), 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
